ring_osc_counter: RTL

Measures the oscillation rate of a free-running CMOS inverter-chain (ring oscillator) output by counting its rising edges over a fixed window of system clock cycles. It sits directly downstream of the inverter chain. It synchronises the asynchronous oscillator node into the clock domain and presents a latched edge count with a done pulse and an overflow flag. Typical use is process/voltage characterisation of inverter delay.

---
 rtl/ring_osc_counter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ring_osc_counter.sv
// Ring-oscillator frequency meter: synchronises an asynchronous oscillator node and
// counts its rising edges over a fixed clk window, latching a saturated total.
module ring_osc_counter #(
  parameter int unsigned WINDOW = 1024,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned      WIN_W    = 20;
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic             s1_q;
  logic             s2_q;
  logic             s3_q;
  logic             osc_rise_s;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] acc_d;
  logic             ovf_acc_q;
  logic             ovf_acc_d;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             busy_q;
  logic             done_q;

  assign osc_rise_s = s2_q & ~s3_q;

  // Two-flop synchroniser plus history flop; free-running in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= osc_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Saturating edge accumulator; an edge arriving at full scale flags overflow instead.
  always_comb begin
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    if (osc_rise_s && (acc_q == CNT_MAX)) begin
      acc_d     = acc_q;
      ovf_acc_d = 1'b1;
    end else if (osc_rise_s) begin
      acc_d     = acc_q + CNT_W'(1);
      ovf_acc_d = ovf_acc_q;
    end else begin
      acc_d     = acc_q;
      ovf_acc_d = ovf_acc_q;
    end
  end

  // Measurement FSM; results latch on entry to DONE so they are valid during the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      win_q      <= '0;
      acc_q      <= '0;
      ovf_acc_q  <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= ST_MEAS;
            busy_q    <= 1'b1;
            win_q     <= WIN_LOAD;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_MEAS: begin
          acc_q     <= acc_d;
          ovf_acc_q <= ovf_acc_d;
          if (win_q == '0) begin
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            count_q    <= acc_d;
            overflow_q <= ovf_acc_d;
          end else begin
            win_q <= win_q - WIN_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
